uart_tx: RTL and testbench



---
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-side valid/ready handshake between a byte source and uart_tx.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       valid;
  logic       ready;

  modport master (output tx_data, output valid, input ready);
  modport slave  (input tx_data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1/1.5/2 stop bits, runtime baud.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry byte FIFO in front of the serialiser.
module uart_tx #(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] baudrate,
  input  logic [1:0]  stop_bits,
  input  logic        parity_en,
  input  logic        parity_type,
  uart_tx_if.slave    bus,
  output logic        busy,
  output logic        tx
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_reg, state_next;
  logic [31:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [31:0] period_reg;
  logic [1:0]  stop_reg;
  logic        par_en_reg;
  logic        par_type_reg;
  logic [7:0]  data_reg;

  logic [31:0] period_now;
  logic        period_ok;
  logic        load;
  logic [31:0] bit_limit;
  logic        bit_end;

  // Bit period from the live baud input; a zero or sub-2-cycle period blocks new frames.
  assign period_now = (baudrate == 32'd0) ? 32'd0 : 32'(CLK_FREQ) / baudrate;
  assign period_ok  = (period_now >= 32'd2);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic        fifo_full, fifo_empty, push;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign load = (state_reg == IDLE) && !fifo_empty && period_ok;
  assign push = bus.valid && bus.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (load) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Registered RAM read: the popped byte lands in data_reg as the frame starts.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[AW-1:0]] <= bus.tx_data;
    if (load) data_reg <= fifo_mem[rd_ptr_reg[AW-1:0]];
  end
`else
  assign load = bus.valid && bus.ready;

  always_ff @(posedge clk) begin
    if (load) data_reg <= bus.tx_data;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      period_reg   <= '0;
      stop_reg     <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      if (load) begin
        period_reg   <= period_now;
        stop_reg     <= stop_bits;
        par_en_reg   <= parity_en;
        par_type_reg <= parity_type;
      end
    end
  end

  // Stop bit length: code 1 is two periods, code 2 is one and a half (half truncated).
  always_comb begin
    bit_limit = period_reg;
    if (state_reg == STOP) begin
      case (stop_reg)
        2'd1:    bit_limit = period_reg << 1;
        2'd2:    bit_limit = period_reg + (period_reg >> 1);
        default: bit_limit = period_reg;
      endcase
    end
  end

  assign bit_end = (baud_cnt_reg == bit_limit - 32'd1);

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    if (state_reg == IDLE) begin
      if (load) begin
        state_next    = START;
        baud_cnt_next = '0;
        bit_cnt_next  = '0;
      end
    end else if (bit_end) begin
      baud_cnt_next = '0;
      case (state_reg)
        START:   state_next = DATA;
        DATA: begin
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = par_en_reg ? PARITY : STOP;
        end
        PARITY:  state_next = STOP;
        default: state_next = IDLE;
      endcase
    end else begin
      baud_cnt_next = baud_cnt_reg + 32'd1;
    end
  end

  always_comb begin
    busy = (state_reg != IDLE);
    case (state_reg)
      START:   tx = 1'b0;
      DATA:    tx = data_reg[bit_cnt_reg];
      PARITY:  tx = (^data_reg) ^ par_type_reg;
      default: tx = 1'b1;
    endcase
`ifdef UART_TX_FIFO_EN
    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte.
    bus.ready = period_ok && (!fifo_full || load);
`else
    bus.ready = period_ok && (state_reg == IDLE);
`endif
  end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor decodes and compares.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int unsigned CLK_FREQ = 25000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] baudrate;
  logic [1:0]  stop_bits;
  logic        parity_en;
  logic        parity_type;
  logic        busy;
  logic        tx;

  uart_tx_if bus_if ();

  uart_tx #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .baudrate(baudrate), .stop_bits(stop_bits),
    .parity_en(parity_en), .parity_type(parity_type), .bus(bus_if),
    .busy(busy), .tx(tx)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned p;
    logic [1:0]  sb;
    bit          pe;
    bit          pt;
    bit          b2b;
    bit          abort;
    int          acc_cyc;
  } frame_t;
  typedef bit wave_t[$];

  frame_t sb_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference frame as a per-cycle line level, straight from the framing rules.
  function automatic wave_t build_wave(input frame_t f);
    wave_t w;
    int unsigned stop_len;
    bit par;
    for (int i = 0; i < int'(f.p); i++) w.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < int'(f.p); i++) w.push_back(f.data[b]);
    if (f.pe) begin
      par = (($countones(f.data) % 2) == 1) ^ f.pt;
      for (int i = 0; i < int'(f.p); i++) w.push_back(par);
    end
    stop_len = (f.sb == 2'd1) ? 2 * f.p : (f.sb == 2'd2) ? f.p + f.p / 2 : f.p;
    for (int i = 0; i < int'(stop_len); i++) w.push_back(1'b1);
    return w;
  endfunction

  // Monitor: on each falling start edge pop the next expected frame and compare cycle by cycle.
  initial begin : monitor
    frame_t f;
    wave_t  w;
    int start_c, bad, first_bad, nframes;
    int prev_start, prev_len;
    bit aborted;
    nframes = 0; prev_start = 0; prev_len = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        start_c = cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          for (int k = 0; k < 100000 && busy === 1'b1; k++) @(negedge clk);
        end else begin
          f = sb_q.pop_front();
          w = build_wave(f);
`ifndef UART_TX_FIFO_EN
          check("start_latency", start_c, f.acc_cyc);
`endif
          if (f.b2b) check("b2b_start_cycle", start_c, prev_start + prev_len + 1);
          bad = 0; first_bad = -1; aborted = 1'b0;
          for (int i = 0; i < w.size(); i++) begin
            if (i > 0) @(negedge clk);
            if (rst === 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== w[i] || busy !== 1'b1
`ifndef UART_TX_FIFO_EN
                || bus_if.ready !== 1'b0
`endif
               ) begin
              bad++;
              if (first_bad < 0) first_bad = i;
            end
          end
          check($sformatf("frame_%02h_aborted", f.data), aborted, f.abort);
          if (aborted) begin
            check("rst_tx", tx, 1);
            check("rst_ready", bus_if.ready, 1);
            check("rst_busy", busy, 0);
            $display("frame %0d: data=%02h abandoned by reset, tx=%b ready=%b busy=%b",
                     nframes, f.data, tx, bus_if.ready, busy);
          end else begin
            check($sformatf("frame_%02h_bad_cycles(first at %0d)", f.data, first_bad), bad, 0);
            @(negedge clk);
            check("end_busy", busy, 0);
`ifndef UART_TX_FIFO_EN
            check("end_ready", bus_if.ready, 1);
`endif
            $display("frame %0d: data=%02h P=%0d par_en=%0d par_type=%0d stop=%0d len=%0d bad_cycles=%0d",
                     nframes, f.data, f.p, f.pe, f.pt, f.sb, w.size(), bad);
            prev_start = start_c;
            prev_len   = w.size();
          end
          nframes++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [31:0] baud, input logic [1:0] sb,
                      input bit pe, input bit pt, input bit b2b, input bit abort);
    frame_t f;
    bit ok;
    ok = 1'b0;
    baudrate = baud; stop_bits = sb; parity_en = pe; parity_type = pt;
    bus_if.tx_data = d; bus_if.valid = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (bus_if.ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    check("accepted", ok, 1);
    if (ok) begin
      f.data = d; f.p = CLK_FREQ / baud; f.sb = sb; f.pe = pe; f.pt = pt;
      f.b2b = b2b; f.abort = abort; f.acc_cyc = cyc;
      sb_q.push_back(f);
    end
  endtask

  task automatic drop();
    bus_if.valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || busy !== 1'b0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", (k < 20000), 1);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int bad, p;
    logic [31:0] baud;
    bit hold;
    baudrate = 32'd2500000; stop_bits = 2'd0; parity_en = 1'b0; parity_type = 1'b0;
    bus_if.valid = 1'b0; bus_if.tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_ready", bus_if.ready, 1);
    check("reset_busy", busy, 0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || bus_if.ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_hold_bad_cycles", bad, 0);
    @(posedge clk); #1;

    send(8'hA5, 32'd2500000, 2'd0, 0, 0, 0, 0); drop(); wait_idle();
    send(8'h03, 32'd2500000, 2'd0, 1, 0, 0, 0); drop(); wait_idle();
    send(8'h03, 32'd2500000, 2'd0, 1, 1, 0, 0); drop(); wait_idle();
    for (int c = 1; c <= 3; c++) begin
      send(8'hFF, 32'd2500000, 2'(c), 0, 0, 0, 0); drop(); wait_idle();
    end

    send(8'h55, 32'd2500000, 2'd0, 0, 0, 0, 0);
    send(8'hAA, 32'd2500000, 2'd0, 0, 0, 1, 0);
    drop(); wait_idle();

    // Degenerate bit periods must never be accepted.
    bus_if.tx_data = 8'h99; bus_if.valid = 1'b1;
    baudrate = 32'd0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("guard_baud0_bad_cycles", bad, 0);
    baudrate = 32'd25000000;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("guard_p1_bad_cycles", bad, 0);
    drop();
    @(posedge clk); #1;
    send(8'h81, 32'd12500000, 2'd0, 0, 0, 0, 0); drop(); wait_idle();

    send(8'hC3, 32'd2500000, 2'd0, 0, 0, 0, 1); drop();
    repeat (35) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    send(8'h3C, 32'd115200, 2'd0, 1, 0, 0, 0); drop(); wait_idle();

    for (int n = 0; n < 30; n++) begin
      p    = $urandom_range(2, 12);
      baud = CLK_FREQ / p;
      hold = (n > 0) && ($urandom_range(0, 1) == 1);
      if (!hold) begin
        drop();
        baudrate  = $urandom;
        stop_bits = 2'($urandom_range(0, 3));
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
      end
      send(8'($urandom), baud, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), hold, 0);
    end
    drop();
    wait_idle();
    check("queue_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
